// File: rtl/rbm_vote_scheduler.sv
// rbm_vote_scheduler: runs repeated stochastic passes of the RBM hidden/classify
// layer pair and accumulates per-class spike votes. After the last pass it runs a
// sequential argmax and hands the winning class out over a valid/ready handshake.
// A per-pass watchdog ends the classification early if the classify layer stalls.
module rbm_vote_scheduler #(
  parameter int output_dim      = 10,
  parameter int count_bitlength = 12,
  parameter int index_bitlength = 4,
  parameter int iteration_num   = 100,
  parameter int timeout_cycles  = 4096
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  layer_reset,
  input  logic                                  layer_finish,
  input  logic [output_dim-1:0]                 layer_spikes,
  output logic [output_dim*count_bitlength-1:0] votes,
  output logic [index_bitlength-1:0]            class_idx,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic                                  timeout
);

  // Counter widths; both are kept at least one bit wide so degenerate
  // parameter values still elaborate.
  localparam int ITW = (iteration_num < 1) ? 1 : $clog2(iteration_num + 1);
  localparam int WDW = (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles);

  localparam logic [ITW-1:0]             ITER_LAST = ITW'(iteration_num);
  localparam logic [WDW-1:0]             WD_LAST   = WDW'(timeout_cycles - 1);
  localparam logic [index_bitlength-1:0] SCAN_LAST = index_bitlength'(output_dim - 1);
  localparam logic [count_bitlength-1:0] VOTE_SAT  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_ARGMAX,
    S_DONE
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [count_bitlength-1:0]  r_votes [output_dim];
  logic [ITW-1:0]              r_iter;
  logic [WDW-1:0]              r_wdog;
  logic [index_bitlength-1:0]  r_scan;
  logic [index_bitlength-1:0]  r_best;
  logic [index_bitlength-1:0]  r_classIdx;
  logic                        r_timeout;

  logic [ITW-1:0]              w_iterNext;
  logic                        w_lastPass;
  logic                        w_expire;
  logic [index_bitlength-1:0]  w_candidate;

  // Pass bookkeeping, watchdog expiry and the running argmax candidate; ties keep the earlier (lower) index.
  always_comb begin
    w_iterNext  = r_iter + ITW'(1);
    w_lastPass  = (w_iterNext == ITER_LAST);
    w_expire    = (r_wdog == WD_LAST);
    w_candidate = (r_votes[r_scan] > r_votes[r_best]) ? r_scan : r_best;
  end

  // State register; reset wins over every other event.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and the Moore outputs; layers are held in reset outside RUN.
  always_comb begin
    w_next       = r_state;
    busy         = (r_state != S_IDLE);
    layer_reset  = 1'b1;
    result_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (iteration_num == 0) ? S_ARGMAX : S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_next = S_RUN;
      end
      S_RUN: begin
        layer_reset = 1'b0;
        if (layer_finish) begin
          w_next = w_lastPass ? S_ARGMAX : S_CLEAR;
        end else if (w_expire) begin
          w_next = S_ARGMAX;
        end
      end
      S_ARGMAX: begin
        if (r_scan == SCAN_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: vote accumulation, pass/watchdog counters, argmax scan and sticky timeout.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < output_dim; i++) begin
        r_votes[i] <= '0;
      end
      r_iter     <= '0;
      r_wdog     <= '0;
      r_scan     <= '0;
      r_best     <= '0;
      r_classIdx <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_scan <= '0;
          r_best <= '0;
          if (start) begin
            for (int i = 0; i < output_dim; i++) begin
              r_votes[i] <= '0;
            end
            r_iter    <= '0;
            r_timeout <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_wdog <= '0;
        end
        S_RUN: begin
          r_wdog <= r_wdog + WDW'(1);
          r_scan <= '0;
          r_best <= '0;
          if (layer_finish) begin
            for (int i = 0; i < output_dim; i++) begin
              if (layer_spikes[i] && (r_votes[i] != VOTE_SAT)) begin
                r_votes[i] <= r_votes[i] + count_bitlength'(1);
              end
            end
            r_iter <= w_iterNext;
          end else if (w_expire) begin
            r_timeout <= 1'b1;
          end
        end
        S_ARGMAX: begin
          r_best <= w_candidate;
          r_scan <= r_scan + index_bitlength'(1);
          if (r_scan == SCAN_LAST) begin
            r_classIdx <= w_candidate;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Flatten the vote array onto the output bus, class i at [i*count_bitlength +: count_bitlength].
  always_comb begin
    votes = '0;
    for (int i = 0; i < output_dim; i++) begin
      votes[i*count_bitlength +: count_bitlength] = r_votes[i];
    end
  end

  assign class_idx = r_classIdx;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rbm_vote_scheduler.sv
// Testbench for rbm_vote_scheduler: randomized passes checked against a
// vote-counting reference model, plus directed tie/saturation, watchdog,
// mid-pass reset and zero-iteration cases.
module tb_rbm_vote_scheduler;

  localparam int DIM  = 4;
  localparam int CB   = 2;
  localparam int IB   = 2;
  localparam int ITER = 5;
  localparam int TO   = 8;
  localparam int VMAX = (1 << CB) - 1;

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic                busy;
  logic                layerReset;
  logic                layerFinish;
  logic [DIM-1:0]      layerSpikes;
  logic [DIM*CB-1:0]   votes;
  logic [IB-1:0]       classIdx;
  logic                resultValid;
  logic                resultReady;
  logic                timeout;

  logic                start0;
  logic                busy0;
  logic                layerReset0;
  logic [DIM*CB-1:0]   votes0;
  logic [IB-1:0]       classIdx0;
  logic                resultValid0;
  logic                resultReady0;
  logic                timeout0;

  int vectorCount = 0;
  int missCount   = 0;

  int modelVotes [DIM];
  int modelClass;
  bit modelTimeout;

  rbm_vote_scheduler #(
    .output_dim(DIM), .count_bitlength(CB), .index_bitlength(IB),
    .iteration_num(ITER), .timeout_cycles(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy),
    .layer_reset(layerReset), .layer_finish(layerFinish), .layer_spikes(layerSpikes),
    .votes(votes), .class_idx(classIdx), .result_valid(resultValid),
    .result_ready(resultReady), .timeout(timeout)
  );

  rbm_vote_scheduler #(
    .output_dim(DIM), .count_bitlength(CB), .index_bitlength(IB),
    .iteration_num(0), .timeout_cycles(TO)
  ) dutZero (
    .clock(clock), .reset(reset), .start(start0), .busy(busy0),
    .layer_reset(layerReset0), .layer_finish(1'b0), .layer_spikes('0),
    .votes(votes0), .class_idx(classIdx0), .result_valid(resultValid0),
    .result_ready(resultReady0), .timeout(timeout0)
  );

  // Free-running clock; the DUT works on the rising edge, the bench on the falling edge.
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DIM*CB-1:0] expVotes();
    logic [DIM*CB-1:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++) begin
      v[i*CB +: CB] = CB'(modelVotes[i]);
    end
    return v;
  endfunction

  function automatic int modelArgmax();
    int best;
    best = 0;
    for (int k = 1; k < DIM; k++) begin
      if (modelVotes[k] > modelVotes[best]) best = k;
    end
    return best;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < DIM; i++) modelVotes[i] = 0;
    modelTimeout = 1'b0;
  endtask

  task automatic modelVote(input logic [DIM-1:0] spk);
    for (int i = 0; i < DIM; i++) begin
      if (spk[i] && modelVotes[i] < VMAX) modelVotes[i]++;
    end
  endtask

  task automatic checkResult(input string tag);
    checkOutput({tag, "_votes"}, 32'(votes), 32'(expVotes()));
    checkOutput({tag, "_class"}, 32'(classIdx), 32'(modelClass));
    checkOutput({tag, "_timeout"}, 32'(timeout), 32'(modelTimeout));
  endtask

  // One full classification. finishAt=0 picks a random finish cycle per pass
  // (values above TO starve the watchdog); spkFixed<0 picks random spikes.
  task automatic applyStimulus(input int finishAt, input int spkFixed);
    int d;
    int holdCycles;
    bit finished;
    logic [DIM-1:0] spk;
    @(negedge clock);
    start = 1'b1;
    modelClear();
    @(negedge clock);
    start = 1'b0;
    checkOutput("start_votes_cleared", 32'(votes), 32'(0));
    checkOutput("start_timeout_cleared", 32'(timeout), 32'(0));
    for (int p = 0; p < ITER; p++) begin
      checkOutput("clear_layer_reset", 32'(layerReset), 32'(1));
      checkOutput("clear_busy", 32'(busy), 32'(1));
      layerFinish = 1'($urandom);
      layerSpikes = DIM'($urandom);
      d = (finishAt != 0) ? finishAt : int'($urandom_range(1, TO + 2));
      finished = 1'b0;
      for (int c = 1; c <= TO; c++) begin
        @(negedge clock);
        checkOutput("run_layer_reset", 32'(layerReset), 32'(0));
        checkOutput("run_valid", 32'(resultValid), 32'(0));
        if (c == d) begin
          spk = (spkFixed >= 0) ? DIM'(spkFixed) : DIM'($urandom);
          layerFinish = 1'b1;
          layerSpikes = spk;
          modelVote(spk);
          finished = 1'b1;
          break;
        end else begin
          layerFinish = 1'b0;
          layerSpikes = DIM'($urandom);
        end
      end
      @(negedge clock);
      layerFinish = 1'b0;
      if (!finished) begin
        modelTimeout = 1'b1;
        break;
      end
    end
    modelClass = modelArgmax();
    for (int i = 0; i < DIM; i++) begin
      checkOutput("argmax_valid_low", 32'(resultValid), 32'(0));
      checkOutput("argmax_layer_reset", 32'(layerReset), 32'(1));
      layerFinish = 1'($urandom);
      layerSpikes = DIM'($urandom);
      @(negedge clock);
    end
    checkOutput("done_valid_latency", 32'(resultValid), 32'(1));
    checkResult("done");
    holdCycles = int'($urandom_range(0, 6));
    for (int j = 0; j < holdCycles; j++) begin
      resultReady = 1'b0;
      start = 1'($urandom);
      @(negedge clock);
      checkOutput("hold_valid", 32'(resultValid), 32'(1));
      checkOutput("hold_busy", 32'(busy), 32'(1));
      checkResult("hold");
    end
    start = 1'b0;
    layerFinish = 1'b0;
    resultReady = 1'b1;
    @(negedge clock);
    resultReady = 1'b0;
    checkOutput("accept_busy", 32'(busy), 32'(0));
    checkOutput("accept_valid", 32'(resultValid), 32'(0));
    checkOutput("accept_layer_reset", 32'(layerReset), 32'(1));
    checkResult("idle_hold");
  endtask

  // Reset in the middle of the second pass must restore every reset value.
  task automatic applyMidReset();
    @(negedge clock);
    start = 1'b1;
    modelClear();
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    layerFinish = 1'b1;
    layerSpikes = 4'b0011;
    @(negedge clock);
    layerFinish = 1'b0;
    checkOutput("midrst_clear_lrst", 32'(layerReset), 32'(1));
    @(negedge clock);
    checkOutput("midrst_run_lrst", 32'(layerReset), 32'(0));
    checkOutput("midrst_votes_pass1", 32'(votes), 32'(8'b0000_0101));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    modelClass = 0;
    checkOutput("midrst_busy", 32'(busy), 32'(0));
    checkOutput("midrst_lrst", 32'(layerReset), 32'(1));
    checkOutput("midrst_valid", 32'(resultValid), 32'(0));
    checkResult("midrst");
  endtask

  // The zero-iteration instance goes straight to argmax and never releases the layers.
  task automatic applyZeroIter();
    @(negedge clock);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    for (int i = 0; i < DIM; i++) begin
      checkOutput("zero_layer_reset", 32'(layerReset0), 32'(1));
      checkOutput("zero_valid_low", 32'(resultValid0), 32'(0));
      checkOutput("zero_busy", 32'(busy0), 32'(1));
      @(negedge clock);
    end
    checkOutput("zero_valid", 32'(resultValid0), 32'(1));
    checkOutput("zero_class", 32'(classIdx0), 32'(0));
    checkOutput("zero_votes", 32'(votes0), 32'(0));
    checkOutput("zero_timeout", 32'(timeout0), 32'(0));
    resultReady0 = 1'b1;
    @(negedge clock);
    resultReady0 = 1'b0;
    checkOutput("zero_accept_busy", 32'(busy0), 32'(0));
  endtask

  // Main sequence: reset/idle checks, directed cases, random classifications.
  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    layerFinish  = 1'b0;
    layerSpikes  = '0;
    resultReady  = 1'b0;
    start0       = 1'b0;
    resultReady0 = 1'b0;
    modelClear();
    modelClass = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("idle_busy", 32'(busy), 32'(0));
      checkOutput("idle_layer_reset", 32'(layerReset), 32'(1));
      checkOutput("idle_valid", 32'(resultValid), 32'(0));
      checkResult("idle_reset");
    end
    applyStimulus(2, 4'b1010);
    applyStimulus(TO + 1, -1);
    applyStimulus(TO, -1);
    applyStimulus(1, 4'b0001);
    for (int n = 0; n < 20; n++) begin
      applyStimulus(0, -1);
    end
    applyMidReset();
    applyZeroIter();
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
